// File: rtl/booth_mult_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : booth_mult_arbiter
//  Description : Round-robin scheduler that shares one sequential Booth
//                multiplier core between N_REQ requesters. Captures operand
//                pairs, drives the core, waits for done (with a watchdog) and
//                returns the tagged product on a shared response channel.
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_mult_arbiter #(
    parameter int N_REQ       = 2,
    parameter int WIDTH       = 8,
    parameter int TIMEOUT_CYC = 64,
    parameter int IDW         = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [IDW-1:0]         resp_id,
    output logic [2*WIDTH-1:0]     resp_result,
    output logic                   resp_err,
    output logic                   mul_start,
    output logic [WIDTH-1:0]       mul_a,
    output logic [WIDTH-1:0]       mul_b,
    input  logic                   mul_done,
    input  logic [2*WIDTH-1:0]     mul_result,
    output logic                   busy
);

    // Watchdog counter only needs to reach TIMEOUT_CYC-1.
    localparam int WDW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDW-1:0]     r_rr_ptr;
    logic [IDW-1:0]     r_resp_id;
    logic [IDW-1:0]     w_gnt;
    logic [IDW-1:0]     w_rr_nxt;
    logic [N_REQ-1:0]   w_gnt_oh;
    logic               w_any;
    logic               w_accept;
    logic               w_wd_last;
    logic [WIDTH-1:0]   r_mul_a;
    logic [WIDTH-1:0]   r_mul_b;
    logic [WIDTH-1:0]   w_sel_a;
    logic [WIDTH-1:0]   w_sel_b;
    logic [2*WIDTH-1:0] r_resp_result;
    logic               r_resp_err;
    logic [WDW-1:0]     r_wd_cnt;

    // Round-robin grant: the valid requester at the smallest rotation
    // distance from r_rr_ptr wins (larger distances are overwritten).
    always_comb begin
        w_any    = 1'b0;
        w_gnt    = '0;
        w_gnt_oh = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req_valid[i] && (((int'(r_rr_ptr) + k) % N_REQ) == i)) begin
                    w_any       = 1'b1;
                    w_gnt       = IDW'(i);
                    w_gnt_oh    = '0;
                    w_gnt_oh[i] = 1'b1;
                end
            end
        end
    end

    // Operand mux for the granted slot.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_gnt_oh[i]) begin
                w_sel_a = req_a[i*WIDTH +: WIDTH];
                w_sel_b = req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // The requester just served gets lowest priority next time.
    assign w_rr_nxt  = (w_gnt == IDW'(N_REQ - 1)) ? '0 : (w_gnt + IDW'(1));
    // Abort when the incremented count would reach TIMEOUT_CYC-1.
    assign w_wd_last = ((int'(r_wd_cnt) + 1) == (TIMEOUT_CYC - 1));

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and request handshake decode.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        req_ready   = '0;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_accept    = 1'b1;
                    req_ready   = w_gnt_oh;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (mul_done || w_wd_last) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Job capture, watchdog count and result latching.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rr_ptr      <= '0;
            r_resp_id     <= '0;
            r_mul_a       <= '0;
            r_mul_b       <= '0;
            r_resp_result <= '0;
            r_resp_err    <= 1'b0;
            r_wd_cnt      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mul_a   <= w_sel_a;
                        r_mul_b   <= w_sel_b;
                        r_resp_id <= w_gnt;
                        r_rr_ptr  <= w_rr_nxt;
                    end
                end
                S_ISSUE: r_wd_cnt <= '0;
                S_WAIT: begin
                    // A done arriving with the final count still wins.
                    if (mul_done) begin
                        r_resp_result <= mul_result;
                        r_resp_err    <= 1'b0;
                    end else if (w_wd_last) begin
                        r_resp_result <= '0;
                        r_resp_err    <= 1'b1;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + WDW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign mul_start   = (r_state == S_ISSUE);
    assign resp_valid  = (r_state == S_RESP);
    assign busy        = (r_state != S_IDLE);
    assign mul_a       = r_mul_a;
    assign mul_b       = r_mul_b;
    assign resp_id     = r_resp_id;
    assign resp_result = r_resp_result;
    assign resp_err    = r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_booth_mult_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_booth_mult_arbiter
//  Description : Self-checking bench for booth_mult_arbiter with a behavioural
//                multiplier-core model and a round-robin reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_mult_arbiter;

    localparam int N_REQ       = 2;
    localparam int WIDTH       = 8;
    localparam int TIMEOUT_CYC = 64;
    localparam int IDW         = 1;
    localparam int PW          = 2 * WIDTH;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic [N_REQ-1:0]       req_valid = '0;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ*WIDTH-1:0] req_a = '0;
    logic [N_REQ*WIDTH-1:0] req_b = '0;
    logic                   resp_valid;
    logic                   resp_ready = 1'b1;
    logic [IDW-1:0]         resp_id;
    logic [PW-1:0]          resp_result;
    logic                   resp_err;
    logic                   mul_start;
    logic [WIDTH-1:0]       mul_a;
    logic [WIDTH-1:0]       mul_b;
    logic                   mul_done = 1'b0;
    logic [PW-1:0]          mul_result = '0;
    logic                   busy;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: rotation pointer and per-requester operands.
    int               model_ptr = 0;
    logic [WIDTH-1:0] opa [N_REQ];
    logic [WIDTH-1:0] opb [N_REQ];

    // Core model controls.
    int               core_lat    = 18;
    bit               core_en     = 1'b1;
    bit               inject_done = 1'b0;
    int               core_cnt    = 0;
    logic [WIDTH-1:0] core_a      = '0;
    logic [WIDTH-1:0] core_b      = '0;

    booth_mult_arbiter #(
        .N_REQ       (N_REQ),
        .WIDTH       (WIDTH),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .IDW         (IDW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_err    (resp_err),
        .mul_start   (mul_start),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_done    (mul_done),
        .mul_result  (mul_result),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // Signed product with plain integer arithmetic.
    function automatic logic [PW-1:0] ref_prod(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        longint pa;
        longint pb;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        return PW'(pa * pb);
    endfunction

    // First valid requester at or after model_ptr, wrapping.
    function automatic int ref_grant(input logic [N_REQ-1:0] mask);
        for (int k = 0; k < N_REQ; k++) begin
            if (mask[(model_ptr + k) % N_REQ]) return (model_ptr + k) % N_REQ;
        end
        return -1;
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input int g);
        logic [N_REQ-1:0] v;
        v = '0;
        if (g >= 0) v[g] = 1'b1;
        return v;
    endfunction

    // Multiplier core: done pulse core_lat cycles after the start pulse.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            core_cnt = 0;
            mul_done = 1'b0;
        end else begin
            mul_done = 1'b0;
            if (core_cnt > 0) begin
                core_cnt--;
                if (core_cnt == 0 && core_en) begin
                    mul_done   = 1'b1;
                    mul_result = ref_prod(core_a, core_b);
                end
            end
            if (inject_done) begin
                mul_done   = 1'b1;
                mul_result = 16'h1234;
            end
            if (mul_start) begin
                core_cnt = core_lat;
                core_a   = mul_a;
                core_b   = mul_b;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL global_timeout: got still running, want finished");
        $fatal(1);
    end

    task automatic drive_ops();
        for (int i = 0; i < N_REQ; i++) begin
            req_a[i*WIDTH +: WIDTH] = opa[i];
            req_b[i*WIDTH +: WIDTH] = opb[i];
        end
    endtask

    task automatic wait_resp(output int cyc, output bit ok);
        ok  = 1'b0;
        cyc = 0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            cyc++;
            if (resp_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_vec++;
        if ({req_ready, resp_valid, resp_id, resp_result, resp_err, mul_start, mul_a, mul_b, busy} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: got rdy=%b rv=%b id=%0d res=%h err=%b st=%b a=%h b=%h busy=%b, want all 0",
                     req_ready, resp_valid, resp_id, resp_result, resp_err, mul_start, mul_a, mul_b, busy);
        end
        rst       = 1'b1;
        model_ptr = 0;
        @(negedge clk);
        n_vec++;
        if ({req_ready, busy, resp_valid} !== '0) begin
            n_err++;
            $display("FAIL reset_idle: got rdy=%b busy=%b rv=%b, want 0", req_ready, busy, resp_valid);
        end
    endtask

    task automatic test_single();
        int cyc;
        bit ok;
        int g;
        @(negedge clk);
        core_lat = 18;
        opa[0] = 8'd7;
        opb[0] = 8'hFD;
        opa[1] = 8'd0;
        opb[1] = 8'd0;
        drive_ops();
        req_valid = 2'b01;
        #1;
        g = ref_grant(2'b01);
        n_vec++;
        if (req_ready !== onehot(g)) begin
            n_err++;
            $display("FAIL single_ready: got %b want %b", req_ready, onehot(g));
        end
        model_ptr = (g + 1) % N_REQ;
        @(negedge clk);
        req_valid = '0;
        n_vec++;
        if ({mul_start, mul_a, mul_b, req_ready} !== {1'b1, 8'd7, 8'hFD, 2'b00}) begin
            n_err++;
            $display("FAIL single_issue: got st=%b a=%h b=%h rdy=%b want st=1 a=07 b=fd rdy=00",
                     mul_start, mul_a, mul_b, req_ready);
        end
        wait_resp(cyc, ok);
        n_vec++;
        if (!ok || cyc != 19) begin
            n_err++;
            $display("FAIL single_latency: got %0d cycles (ok=%b) want 19", cyc, ok);
        end
        n_vec++;
        if ({resp_id, resp_result, resp_err} !== {1'b0, 16'hFFEB, 1'b0}) begin
            n_err++;
            $display("FAIL single_resp: got id=%0d res=%h err=%b want id=0 res=ffeb err=0",
                     resp_id, resp_result, resp_err);
        end
        @(negedge clk);
        n_vec++;
        if ({resp_valid, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL single_release: got rv=%b busy=%b want 0 0", resp_valid, busy);
        end
    endtask

    task automatic test_round_robin();
        int prev_g = -1;
        @(negedge clk);
        for (int i = 0; i < N_REQ; i++) begin
            opa[i] = WIDTH'($urandom);
            opb[i] = WIDTH'($urandom);
        end
        drive_ops();
        req_valid = 2'b11;
        for (int j = 0; j < 6; j++) begin
            int g;
            int cyc;
            bit ok;
            logic [PW-1:0] exp_r;
            core_lat = $urandom_range(1, 40);
            #1;
            g = ref_grant(req_valid);
            n_vec++;
            if (req_ready !== onehot(g) || g == prev_g) begin
                n_err++;
                $display("FAIL rr_grant%0d: got %b want %b (prev %0d)", j, req_ready, onehot(g), prev_g);
            end
            prev_g    = g;
            model_ptr = (g + 1) % N_REQ;
            exp_r     = ref_prod(opa[g], opb[g]);
            @(negedge clk);
            n_vec++;
            if ({mul_start, mul_a, mul_b} !== {1'b1, opa[g], opb[g]}) begin
                n_err++;
                $display("FAIL rr_issue%0d: got st=%b a=%h b=%h want 1 %h %h", j, mul_start, mul_a, mul_b, opa[g], opb[g]);
            end
            opa[g] = WIDTH'($urandom);
            opb[g] = WIDTH'($urandom);
            drive_ops();
            wait_resp(cyc, ok);
            n_vec++;
            if (!ok || {resp_id, resp_result, resp_err} !== {IDW'(g), exp_r, 1'b0}) begin
                n_err++;
                $display("FAIL rr_resp%0d: got id=%0d res=%h err=%b (ok=%b) want id=%0d res=%h err=0",
                         j, resp_id, resp_result, resp_err, ok, g, exp_r);
            end
            @(negedge clk);
        end
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int g;
        int cyc;
        bit ok;
        logic [PW-1:0] exp_r;
        @(negedge clk);
        core_lat = 10;
        for (int i = 0; i < N_REQ; i++) begin
            opa[i] = WIDTH'($urandom);
            opb[i] = WIDTH'($urandom);
        end
        drive_ops();
        resp_ready = 1'b0;
        req_valid  = 2'b10;
        #1;
        g = ref_grant(2'b10);
        n_vec++;
        if (req_ready !== onehot(g)) begin
            n_err++;
            $display("FAIL bp_grant: got %b want %b", req_ready, onehot(g));
        end
        model_ptr = (g + 1) % N_REQ;
        exp_r     = ref_prod(opa[g], opb[g]);
        @(negedge clk);
        req_valid = 2'b11;
        wait_resp(cyc, ok);
        n_vec++;
        if (!ok || cyc != 11) begin
            n_err++;
            $display("FAIL bp_latency: got %0d cycles (ok=%b) want 11", cyc, ok);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_vec++;
            if ({req_ready, resp_valid, resp_id, resp_result, resp_err} !== {2'b00, 1'b1, IDW'(g), exp_r, 1'b0}) begin
                n_err++;
                $display("FAIL bp_hold%0d: got rdy=%b rv=%b id=%0d res=%h err=%b want 00 1 %0d %h 0",
                         k, req_ready, resp_valid, resp_id, resp_result, resp_err, g, exp_r);
            end
        end
        req_valid  = '0;
        resp_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (resp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_release: got rv=%b want 0", resp_valid);
        end
    endtask

    task automatic test_watchdog();
        int g;
        int cyc;
        bit ok;
        @(negedge clk);
        core_en = 1'b0;
        opa[0]  = WIDTH'($urandom);
        opb[0]  = WIDTH'($urandom);
        drive_ops();
        req_valid = 2'b01;
        #1;
        g         = ref_grant(2'b01);
        model_ptr = (g + 1) % N_REQ;
        @(negedge clk);
        req_valid = '0;
        wait_resp(cyc, ok);
        n_vec++;
        if (!ok || cyc != TIMEOUT_CYC) begin
            n_err++;
            $display("FAIL wd_latency: got %0d cycles (ok=%b) want %0d", cyc, ok, TIMEOUT_CYC);
        end
        n_vec++;
        if ({resp_id, resp_result, resp_err} !== {IDW'(g), 16'h0000, 1'b1}) begin
            n_err++;
            $display("FAIL wd_resp: got id=%0d res=%h err=%b want id=%0d res=0000 err=1",
                     resp_id, resp_result, resp_err, g);
        end
        core_en = 1'b1;
        @(negedge clk);
        inject_done = 1'b1;
        @(negedge clk);
        inject_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_vec++;
            if ({resp_valid, busy} !== 2'b00) begin
                n_err++;
                $display("FAIL wd_stray_done%0d: got rv=%b busy=%b want 0 0", k, resp_valid, busy);
            end
        end
    endtask

    task automatic test_reset_mid_wait();
        int g;
        int cyc;
        bit ok;
        @(negedge clk);
        core_lat = 30;
        opa[0]   = WIDTH'($urandom);
        opb[0]   = WIDTH'($urandom);
        drive_ops();
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = '0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        n_vec++;
        if ({req_ready, resp_valid, resp_id, resp_result, resp_err, mul_start, mul_a, mul_b, busy} !== '0) begin
            n_err++;
            $display("FAIL rst_mid_outputs: got rv=%b id=%0d res=%h err=%b st=%b a=%h b=%h busy=%b, want all 0",
                     resp_valid, resp_id, resp_result, resp_err, mul_start, mul_a, mul_b, busy);
        end
        model_ptr = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        core_lat = 5;
        for (int i = 0; i < N_REQ; i++) begin
            opa[i] = WIDTH'($urandom);
            opb[i] = WIDTH'($urandom);
        end
        drive_ops();
        req_valid = 2'b11;
        #1;
        g = ref_grant(2'b11);
        n_vec++;
        if (req_ready !== onehot(g)) begin
            n_err++;
            $display("FAIL rst_mid_first_grant: got %b want %b", req_ready, onehot(g));
        end
        model_ptr = (g + 1) % N_REQ;
        @(negedge clk);
        req_valid = '0;
        wait_resp(cyc, ok);
        n_vec++;
        if (!ok || {resp_id, resp_result, resp_err} !== {IDW'(g), ref_prod(opa[g], opb[g]), 1'b0}) begin
            n_err++;
            $display("FAIL rst_mid_resp: got id=%0d res=%h err=%b (ok=%b) want id=%0d res=%h",
                     resp_id, resp_result, resp_err, ok, g, ref_prod(opa[g], opb[g]));
        end
        @(negedge clk);
    endtask

    task automatic test_corner();
        logic [WIDTH-1:0] ca [3];
        logic [WIDTH-1:0] cb [3];
        logic [PW-1:0]    ce [3];
        ca = '{8'h80, 8'h00, 8'h7F};
        cb = '{8'h80, 8'h7F, 8'hFF};
        ce = '{16'h4000, 16'h0000, 16'hFF81};
        for (int j = 0; j < 3; j++) begin
            int r;
            int cyc;
            bit ok;
            @(negedge clk);
            r        = j % N_REQ;
            core_lat = 7;
            opa[r]   = ca[j];
            opb[r]   = cb[j];
            drive_ops();
            req_valid = onehot(r);
            #1;
            model_ptr = (ref_grant(onehot(r)) + 1) % N_REQ;
            @(negedge clk);
            req_valid = '0;
            wait_resp(cyc, ok);
            n_vec++;
            if (!ok || {resp_id, resp_result, resp_err} !== {IDW'(r), ce[j], 1'b0}) begin
                n_err++;
                $display("FAIL corner%0d: got id=%0d res=%h err=%b (ok=%b) want id=%0d res=%h err=0",
                         j, resp_id, resp_result, resp_err, ok, r, ce[j]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 20; j++) begin
            logic [N_REQ-1:0] mask;
            logic [PW-1:0]    exp_r;
            int               g;
            int               lat;
            int               cyc;
            bit               ok;
            @(negedge clk);
            mask = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
            for (int i = 0; i < N_REQ; i++) begin
                opa[i] = WIDTH'($urandom);
                opb[i] = WIDTH'($urandom);
            end
            drive_ops();
            lat        = $urandom_range(1, 50);
            core_lat   = lat;
            resp_ready = 1'b0;
            req_valid  = mask;
            #1;
            g = ref_grant(mask);
            n_vec++;
            if (req_ready !== onehot(g)) begin
                n_err++;
                $display("FAIL rand%0d_grant: got %b want %b (mask %b)", j, req_ready, onehot(g), mask);
            end
            model_ptr = (g + 1) % N_REQ;
            exp_r     = ref_prod(opa[g], opb[g]);
            @(negedge clk);
            req_valid = '0;
            n_vec++;
            if ({mul_start, mul_a, mul_b} !== {1'b1, opa[g], opb[g]}) begin
                n_err++;
                $display("FAIL rand%0d_issue: got st=%b a=%h b=%h want 1 %h %h", j, mul_start, mul_a, mul_b, opa[g], opb[g]);
            end
            wait_resp(cyc, ok);
            n_vec++;
            if (!ok || cyc != lat + 1 || {resp_id, resp_result, resp_err} !== {IDW'(g), exp_r, 1'b0}) begin
                n_err++;
                $display("FAIL rand%0d_resp: got cyc=%0d id=%0d res=%h err=%b (ok=%b) want cyc=%0d id=%0d res=%h err=0",
                         j, cyc, resp_id, resp_result, resp_err, ok, lat + 1, g, exp_r);
            end
            for (int k = 0; k < 8; k++) begin
                if ($urandom_range(0, 2) == 0) break;
                @(negedge clk);
                n_vec++;
                if ({resp_valid, resp_id, resp_result, resp_err} !== {1'b1, IDW'(g), exp_r, 1'b0}) begin
                    n_err++;
                    $display("FAIL rand%0d_hold: got rv=%b id=%0d res=%h err=%b want 1 %0d %h 0",
                             j, resp_valid, resp_id, resp_result, resp_err, g, exp_r);
                end
            end
            resp_ready = 1'b1;
            @(negedge clk);
            n_vec++;
            if (resp_valid !== 1'b0) begin
                n_err++;
                $display("FAIL rand%0d_release: got rv=%b want 0", j, resp_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_watchdog();
        test_reset_mid_wait();
        test_corner();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
